// File: rtl/mac_tree_acc.sv
// rtl/mac_tree_acc.sv - signed lane MAC: registered products, registered adder tree, run accumulator.
// Optional saturation of the accumulator is enabled with `define MAC_SAT_EN.
module mac_tree_acc #(
   parameter int DATA_WIDTH = 8,
   parameter int TREE_SIZE  = 9,
   parameter int ACC_WIDTH  = 32
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             in_last,
   input  logic [DATA_WIDTH*TREE_SIZE-1:0]  in,
   input  logic [DATA_WIDTH*TREE_SIZE-1:0]  kernel,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [ACC_WIDTH-1:0]             out,
   output logic                             out_sat
);

   function automatic int lvl_cnt(input int l);
      int n;
      n = TREE_SIZE;
      for (int i = 0; i < l; i++) n = (n + 1) / 2;
      return n;
   endfunction

   function automatic int lvl_off(input int l);
      int o;
      o = 0;
      for (int i = 0; i < l; i++) o = o + lvl_cnt(i);
      return o;
   endfunction

   localparam int LEVELS = $clog2(TREE_SIZE);
   localparam int TW     = 2 * DATA_WIDTH + LEVELS;
   // All tree levels share one flat node array; level l starts at lvl_off(l).
   localparam int NODES  = lvl_off(LEVELS + 1);
   localparam int ROOT   = NODES - 1;

   logic signed [2*DATA_WIDTH-1:0] prod [TREE_SIZE];
   logic signed [TW-1:0]           node_q [NODES];
   logic signed [TW-1:0]           node_d [NODES];
   logic [LEVELS:0]                vld_q;
   logic [LEVELS:0]                last_q;
   logic signed [ACC_WIDTH-1:0]    acc_q;
   logic signed [ACC_WIDTH-1:0]    tsum;
   logic signed [ACC_WIDTH-1:0]    sum_d;
   logic [ACC_WIDTH-1:0]           out_q;
   logic                           out_valid_q;
   logic                           adv;

   assign adv       = !out_valid_q || out_ready;
   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign out       = out_q;

   always_comb begin
      for (int i = 0; i < NODES; i++) node_d[i] = '0;
      for (int i = 0; i < TREE_SIZE; i++) begin
         prod[i]   = $signed(in[i*DATA_WIDTH +: DATA_WIDTH]) * $signed(kernel[i*DATA_WIDTH +: DATA_WIDTH]);
         node_d[i] = TW'(prod[i]);
      end
      // An unpaired last node of a level is carried forward unchanged.
      for (int l = 1; l <= LEVELS; l++) begin
         for (int j = 0; j < lvl_cnt(l); j++) begin
            if (2 * j + 1 < lvl_cnt(l - 1))
               node_d[lvl_off(l) + j] = node_q[lvl_off(l - 1) + 2 * j] + node_q[lvl_off(l - 1) + 2 * j + 1];
            else
               node_d[lvl_off(l) + j] = node_q[lvl_off(l - 1) + 2 * j];
         end
      end
   end

   assign tsum = ACC_WIDTH'(node_q[ROOT]);

`ifdef MAC_SAT_EN
   logic [ACC_WIDTH:0] wide;
   logic               clamp;
   logic               sticky_q;
   logic               out_sat_q;

   always_comb begin
      wide  = (ACC_WIDTH + 1)'(acc_q) + (ACC_WIDTH + 1)'(tsum);
      clamp = wide[ACC_WIDTH] != wide[ACC_WIDTH-1];
      if (!clamp)
         sum_d = wide[ACC_WIDTH-1:0];
      else if (wide[ACC_WIDTH])
         sum_d = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else
         sum_d = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   end

   assign out_sat = out_sat_q;
`else
   assign sum_d   = acc_q + tsum;
   assign out_sat = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         vld_q       <= '0;
         last_q      <= '0;
         acc_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
`ifdef MAC_SAT_EN
         sticky_q    <= 1'b0;
         out_sat_q   <= 1'b0;
`endif
      end else if (adv) begin
         node_q      <= node_d;
         vld_q       <= {vld_q[LEVELS-1:0], in_valid};
         last_q      <= {last_q[LEVELS-1:0], in_last};
         out_valid_q <= vld_q[LEVELS] && last_q[LEVELS];
         if (vld_q[LEVELS]) begin
            if (last_q[LEVELS]) begin
               out_q     <= sum_d;
               acc_q     <= '0;
`ifdef MAC_SAT_EN
               out_sat_q <= sticky_q || clamp;
               sticky_q  <= 1'b0;
`endif
            end else begin
               acc_q     <= sum_d;
`ifdef MAC_SAT_EN
               sticky_q  <= sticky_q || clamp;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_mac_tree_acc.sv
// tb/tb_mac_tree_acc.sv - randomized and directed bench for mac_tree_acc against a dot-product run model.
module tb_mac_tree_acc;
   localparam int DW   = 8;
   localparam int TS   = 9;
   localparam int AW   = 32;
   localparam int AW20 = 20;

   logic              clock = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_last;
   logic              out_ready;
   logic [DW*TS-1:0]  in_v;
   logic [DW*TS-1:0]  kern_v;
   logic              in_ready, out_valid, out_sat;
   logic [AW-1:0]     out_v;
   logic              in_ready20, out_valid20, out_sat20;
   logic [AW20-1:0]   out20;

   always #5 clock = ~clock;

   mac_tree_acc #(.DATA_WIDTH(DW), .TREE_SIZE(TS), .ACC_WIDTH(AW)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .in(in_v), .kernel(kern_v), .out_valid(out_valid), .out_ready(out_ready), .out(out_v), .out_sat(out_sat));

   mac_tree_acc #(.DATA_WIDTH(DW), .TREE_SIZE(TS), .ACC_WIDTH(AW20)) dut20 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready20), .in_last(in_last),
      .in(in_v), .kernel(kern_v), .out_valid(out_valid20), .out_ready(out_ready), .out(out20), .out_sat(out_sat20));

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   typedef struct { longint v32; bit s32; longint v20; bit s20; } res_t;
   res_t   exp_q[$];
   longint acc32, acc20;
   bit     st32, st20;

   function automatic longint fold(input longint v, input int w, output bit clamp);
      longint hi, lo, r;
      hi    = (longint'(1) <<< (w - 1)) - 1;
      lo    = -(longint'(1) <<< (w - 1));
      clamp = 1'b0;
      r     = v;
`ifdef MAC_SAT_EN
      if (v > hi) begin clamp = 1'b1; r = hi; end
      else if (v < lo) begin clamp = 1'b1; r = lo; end
`else
      r = v & ((longint'(1) <<< w) - 1);
      if (r > hi) r = r - (longint'(1) <<< w);
`endif
      return r;
   endfunction

   // Scoreboard: the model acts on every accepted beat; results are checked when handed over.
   res_t            r;
   longint          dot;
   bit              c;
   bit              hold = 1'b0;
   logic [AW-1:0]   held;
   logic [AW20-1:0] held20;
   int              n_out = 0;

   always @(negedge clock) begin
      if (!reset) begin
         exp_q.delete();
         acc32 = 0; acc20 = 0; st32 = 0; st20 = 0;
         hold  = 1'b0;
      end else begin
         if (hold) begin
            check("hold_out", out_v, held);
            check("hold_out20", out20, held20);
            check("hold_valid", out_valid, 1);
         end
         hold   = out_valid && !out_ready;
         held   = out_v;
         held20 = out20;
         check("in_ready", in_ready, !out_valid || out_ready);
         check("in_ready20", in_ready20, !out_valid20 || out_ready);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", out_valid, 0);
            end else begin
               r = exp_q.pop_front();
               n_out++;
               check("out32", $signed(out_v), r.v32);
               check("sat32", out_sat, r.s32);
               check("valid20", out_valid20, 1);
               check("out20", $signed(out20), r.v20);
               check("sat20", out_sat20, r.s20);
            end
         end
         if (in_valid && in_ready) begin
            dot = 0;
            for (int i = 0; i < TS; i++)
               dot += longint'($signed(in_v[i*DW +: DW])) * longint'($signed(kern_v[i*DW +: DW]));
            acc32 = fold(acc32 + dot, AW, c);   st32 |= c;
            acc20 = fold(acc20 + dot, AW20, c); st20 |= c;
            if (in_last) begin
               exp_q.push_back('{v32: acc32, s32: st32, v20: acc20, s20: st20});
               acc32 = 0; acc20 = 0; st32 = 0; st20 = 0;
            end
         end
      end
   end

   task automatic set_lanes(input int a, input int k);
      for (int i = 0; i < TS; i++) begin
         in_v[i*DW +: DW]   = DW'(a);
         kern_v[i*DW +: DW] = DW'(k);
      end
   endtask

   task automatic set_rand();
      for (int i = 0; i < TS; i++) begin
         in_v[i*DW +: DW]   = DW'($urandom);
         kern_v[i*DW +: DW] = DW'($urandom);
      end
   endtask

   task automatic send_beat(input bit last);
      int t;
      bit ok;
      t = 0; ok = 1'b0;
      in_valid = 1'b1;
      in_last  = last;
      while (!ok && t < 200) begin
         @(negedge clock);
         ok = in_ready;
         @(posedge clock); #1;
         t++;
      end
      if (!ok) check("accept_timeout", ok, 1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (n) begin @(posedge clock); #1; end
   endtask

   task automatic wait_result(output longint v32, output longint v20, output bit s32, output bit s20, output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin @(posedge clock); #1; lat++; end
      if (!out_valid) check("result_timeout", out_valid, 1);
      v32 = $signed(out_v); v20 = $signed(out20); s32 = out_sat; s20 = out_sat20;
   endtask

   longint v32, v20;
   bit     s32, s20;
   int     lat, n0;
   bit     rnd_done;

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      set_lanes(0, 0);
      repeat (2) begin @(posedge clock); #1; end
      check("rst_out_valid", out_valid, 0);
      check("rst_out", out_v, 0);
      check("rst_out_sat", out_sat, 0);
      check("rst_in_ready", in_ready, 1);
      reset = 1'b1;
      idle(1);

      set_lanes(1, 2);
      send_beat(1); idle(0);
      wait_result(v32, v20, s32, s20, lat);
      check("ones_x_two", v32, 18);
      check("latency", lat, 6);
      idle(4);

      set_lanes(-128, 127);
      send_beat(1); idle(0);
      wait_result(v32, v20, s32, s20, lat);
      check("neg_extreme", v32, -146304);
      check("neg_extreme_sat", s32, 0);
      idle(4);

      set_lanes(1, 1); send_beat(0); idle(2);
      set_lanes(2, 1); send_beat(0);
      set_lanes(3, 1); send_beat(1); idle(0);
      wait_result(v32, v20, s32, s20, lat);
      check("three_beat", v32, 54);
      idle(4);

      n0 = n_out;
      fork
         begin
            for (int b = 0; b < 12; b++) begin set_rand(); send_beat(1); end
            idle(0);
         end
         begin
            repeat (8) @(posedge clock);
            #1 out_ready = 1'b0;
            repeat (5) begin @(negedge clock); check("bp_in_ready", in_ready, 0); end
            @(posedge clock); #1 out_ready = 1'b1;
         end
      join
      idle(15);
      check("stream_count", n_out - n0, 12);

      set_lanes(127, 127);
      repeat (3) send_beat(0);
      send_beat(1); idle(0);
      wait_result(v32, v20, s32, s20, lat);
      check("wide_acc", v32, 580644);
`ifdef MAC_SAT_EN
      check("acc20_out", v20, 524287);
      check("acc20_sat", s20, 1);
`else
      check("acc20_out", v20, -467932);
      check("acc20_sat", s20, 0);
`endif
      idle(4);

      n0 = n_out;
      set_lanes(1, 1);
      send_beat(0); send_beat(0); idle(0);
      reset = 1'b0;
      @(posedge clock); #1 reset = 1'b1;
      set_lanes(1, 2);
      send_beat(1); idle(0);
      wait_result(v32, v20, s32, s20, lat);
      check("post_reset", v32, 18);
      idle(12);
      check("post_reset_count", n_out - n0, 1);

      rnd_done = 1'b0;
      fork
         begin
            for (int run = 0; run < 30; run++) begin
               int nb;
               nb = $urandom_range(1, 4);
               for (int b = 0; b < nb; b++) begin
                  set_rand();
                  send_beat(b == nb - 1);
                  if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
               end
            end
            idle(0);
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin @(posedge clock); #1 out_ready = ($urandom_range(0, 2) != 0); end
            out_ready = 1'b1;
         end
      join

      idle(20);
      check("drain", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mac_tree_acc.md
MAC_TREE_ACC -- requirements
Module: mac_tree_acc

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: signed operand width per lane.
REQ-002 The block SHALL have parameter TREE_SIZE, default 9: lanes per beat; any value >= 2, not limited to powers of two.
REQ-003 The block SHALL have parameter ACC_WIDTH, default 32: accumulator and result width; must be >= TW, where TW = 2*DATA_WIDTH + ceil(log2(TREE_SIZE)).
REQ-004 The block SHALL have port clock, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: beat present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: beat accepted when in_valid and in_ready are both high.
REQ-008 The block SHALL have port in_last, input, 1 bit: final beat of the current dot-product run.
REQ-009 The block SHALL have port in, input, DATA_WIDTH*TREE_SIZE bits: lane i occupies [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
REQ-010 The block SHALL have port kernel, input, DATA_WIDTH*TREE_SIZE bits: weights, same lane packing as in.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 The block SHALL have port out, output, ACC_WIDTH bits: signed run sum.
REQ-014 The block SHALL have port out_sat, output, 1 bit: the run saturated.

Function
REQ-015 Operands SHALL be two's complement; each product SHALL be a full-precision signed 2*DATA_WIDTH-bit value.
REQ-016 Lane products SHALL be registered (stage 1), then summed by a registered binary tree of ceil(log2(TREE_SIZE)) stages at TW bits with sign extension; odd nodes SHALL pass through a register unchanged.
REQ-017 The tree sum SHALL be sign-extended to ACC_WIDTH and added into the accumulator in the final stage.
REQ-018 Latency SHALL be ceil(log2(TREE_SIZE)) + 2 cycles from acceptance of the in_last beat to out_valid (6 cycles at TREE_SIZE=9), assuming no stall.
REQ-019 Non-last beats SHALL update the accumulator only and SHALL NOT raise out_valid.
REQ-020 The last beat SHALL present accumulator + tree sum on out, set out_valid, and clear the accumulator to 0 so the next beat starts a new run.
REQ-021 Idle cycles (in_valid low) inside a run SHALL leave the accumulator unchanged; a valid flag SHALL travel with each pipeline stage.
REQ-022 The pipeline advance enable SHALL be adv = !out_valid || out_ready; in_ready SHALL equal adv.
REQ-023 When adv is low, all stages, out, out_valid, and out_sat SHALL hold their values.
REQ-024 A result held under backpressure SHALL remain stable until the cycle in which out_ready is high, with no loss and no duplication.
REQ-025 When out_valid and out_ready are both high and a new last beat exits the tree in the same cycle, the new result SHALL replace the old one, and out_valid SHALL stay high.
REQ-026 Single-beat runs (in_last on every beat) SHALL produce one result per beat at full throughput.

Reset
REQ-027 While reset is low at a clock edge, all pipeline valid flags, the accumulator, out, and out_sat SHALL be cleared to 0, out_valid SHALL be 0, and in_ready SHALL be 1 on the following cycle.
REQ-028 A reset asserted mid-run or mid-pipeline SHALL discard all partial sums and in-flight beats; no result from before the reset SHALL ever appear.

Configuration
REQ-029 With macro MAC_SAT_EN defined, the accumulator add SHALL saturate to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
REQ-030 With MAC_SAT_EN defined, a clamped add SHALL set a per-run sticky flag, which is reported on out_sat with the run result and then cleared.
REQ-031 Without MAC_SAT_EN, the accumulator SHALL wrap modulo 2^ACC_WIDTH, and out_sat SHALL be constant 0.

Verification (DATA_WIDTH=8, TREE_SIZE=9 unless stated)
REQ-032 Bench SHALL drive all lanes in=1, kernel=2, in_last=1 as a single beat and check out=18, with out_valid exactly 6 cycles after acceptance.
REQ-033 Bench SHALL drive all lanes in=-128, kernel=127 as a single beat and check out=-146304, out_sat=0.
REQ-034 Bench SHALL run 3 beats with lane values 1, 2, 3 (kernel=1) and 2 idle cycles between beats 1 and 2, and check one result of 54 with no out_valid on the non-last beats.
REQ-035 Bench SHALL stream single-beat runs, hold out_ready low for 5 cycles, and check out stable, in_ready=0, and every result delivered once in order.
REQ-036 Bench SHALL set ACC_WIDTH=20 and run 4 beats of all lanes 127*127 (145161 per beat), and check out=524287 with out_sat=1 when MAC_SAT_EN is defined, and out=-467932 with out_sat=0 when it is not.
REQ-037 Bench SHALL pulse reset low for 1 cycle after 2 beats of a 3-beat run, then send a fresh single-beat run of value 18, and check the only result is 18.
